// File: rtl/des_key_schedule_if.sv
// Key-load handshake and round-key bus between a DES key source and the key schedule.
interface des_key_schedule_if;
    logic [63:0]  key_in;
    logic         key_valid_in;
    logic         decrypt_in;
    logic         key_ready_out;
    logic [767:0] round_keys_out;
    logic         keys_valid_out;
    logic         keys_done_out;

    modport master (
        output key_in, key_valid_in, decrypt_in,
        input  key_ready_out, round_keys_out, keys_valid_out, keys_done_out
    );

    modport slave (
        input  key_in, key_valid_in, decrypt_in,
        output key_ready_out, round_keys_out, keys_valid_out, keys_done_out
    );
endinterface

// File: rtl/des_key_schedule.sv
// Iterative DES key schedule: one round key per cycle into a 16-slot bus, slot 0
// always holding the key the round pipeline consumes first (K1 encrypt, K16 decrypt).
module des_key_schedule (
    input  logic                clk,
    input  logic                rst,
    des_key_schedule_if.slave   kif
);

    typedef enum logic [1:0] {IDLE, GEN, DONE} state_t;

    localparam int unsigned PC1_TBL [56] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    localparam int unsigned PC2_TBL [48] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    // Table entries are FIPS bit numbers (1 = MSB), hence the reversed indexing.
    function automatic logic [55:0] pc1(input logic [63:0] k);
        logic [55:0] r;
        r = '0;
        for (int unsigned j = 0; j < 56; j++)
            r[6'(55 - j)] = k[6'(64 - PC1_TBL[j])];
        return r;
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] cd);
        logic [47:0] r;
        r = '0;
        for (int unsigned j = 0; j < 48; j++)
            r[6'(47 - j)] = cd[6'(56 - PC2_TBL[j])];
        return r;
    endfunction

    state_t             state, state_nxt;
    logic [27:0]        c_reg, d_reg;
    logic [27:0]        c_rot, d_rot;
    logic [3:0]         round_cnt;
    logic [3:0]         slot_idx;
    logic               decrypt_q;
    logic               done_q;
    logic               ready;
    logic               load;
    logic               last_round;
    logic               one_step;
    logic [55:0]        pc1_key;
    logic [47:0]        round_key;
    logic [0:15][47:0]  key_slots;

    always_comb begin
        ready      = rst || (state != GEN);
        load       = kif.key_valid_in && ready;
        last_round = (round_cnt == 4'd15);
        one_step   = (round_cnt == 4'd0) || (round_cnt == 4'd1) ||
                     (round_cnt == 4'd8) || (round_cnt == 4'd15);
        c_rot      = one_step ? {c_reg[26:0], c_reg[27]} : {c_reg[25:0], c_reg[27:26]};
        d_rot      = one_step ? {d_reg[26:0], d_reg[27]} : {d_reg[25:0], d_reg[27:26]};
        round_key  = pc2({c_rot, d_rot});
        slot_idx   = decrypt_q ? (4'd15 - round_cnt) : round_cnt;
        pc1_key    = pc1(kif.key_in);
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (load) state_nxt = GEN;
            GEN:     if (last_round) state_nxt = DONE;
            DONE:    if (load) state_nxt = GEN;
            default: state_nxt = IDLE;
        endcase
    end

    // Slots are only overwritten as each round completes; earlier contents persist.
    always_ff @(posedge clk) begin
        if (rst) begin
            c_reg     <= '0;
            d_reg     <= '0;
            round_cnt <= '0;
            decrypt_q <= 1'b0;
            done_q    <= 1'b0;
            key_slots <= '0;
        end else begin
            done_q <= (state == GEN) && last_round;
            if (load) begin
                c_reg     <= pc1_key[55:28];
                d_reg     <= pc1_key[27:0];
                decrypt_q <= kif.decrypt_in;
                round_cnt <= '0;
            end else if (state == GEN) begin
                c_reg               <= c_rot;
                d_reg               <= d_rot;
                key_slots[slot_idx] <= round_key;
                if (!last_round) round_cnt <= round_cnt + 4'd1;
            end
        end
    end

    assign kif.key_ready_out  = ready;
    assign kif.keys_valid_out = !rst && (state == DONE);
    assign kif.keys_done_out  = !rst && done_q;
    assign kif.round_keys_out = key_slots;

endmodule

// File: tb/tb_des_key_schedule.sv
// Randomized scoreboard bench for des_key_schedule against a table-driven DES key schedule model.
module tb_des_key_schedule;

    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };
    localparam int PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };
    localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    localparam logic [63:0] VEC_KEY = 64'h133457799BBCDFF1;
    localparam logic [47:0] VEC_K1  = 48'h1B02EFFC7072;
    localparam logic [47:0] VEC_K16 = 48'hCB3D8B0E17F5;

    typedef struct {
        logic [767:0] keys;
        int unsigned  due;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    des_key_schedule_if kif ();
    des_key_schedule dut (.clk(clk), .rst(rst), .kif(kif));

    exp_t        sb_q [$];
    int unsigned checks = 0;
    int unsigned failures = 0;
    int unsigned cyc = 0;
    int unsigned done_pulses = 0;
    int unsigned loads = 0;
    int unsigned aborted = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [767:0] act, input logic [767:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Reference: cumulative left rotation of C/D taken from PC-1, then PC-2.
    function automatic logic [767:0] ref_sched(input logic [63:0] key, input logic dec);
        bit           kb [1:64];
        bit           c [28];
        bit           d [28];
        bit           cd [56];
        int           tot;
        int           slot;
        logic [767:0] out;
        out = '0;
        tot = 0;
        for (int n = 1; n <= 64; n++) kb[n] = key[64 - n];
        for (int j = 0; j < 28; j++) begin
            c[j] = kb[PC1_T[j]];
            d[j] = kb[PC1_T[j + 28]];
        end
        for (int r = 0; r < 16; r++) begin
            tot += SHIFTS[r];
            for (int j = 0; j < 28; j++) begin
                cd[j]      = c[(j + tot) % 28];
                cd[j + 28] = d[(j + tot) % 28];
            end
            slot = dec ? 15 - r : r;
            for (int m = 0; m < 48; m++) out[767 - 48 * slot - m] = cd[PC2_T[m] - 1];
        end
        return out;
    endfunction

    function automatic logic [47:0] slot_of(input logic [767:0] v, input int s);
        return v[767 - 48 * s -: 48];
    endfunction

    // Monitor: every rising keys_valid_out retires one scoreboard entry.
    initial begin
        logic prev_valid;
        exp_t e;
        prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (kif.keys_done_out) done_pulses++;
            if (!rst && kif.keys_valid_out && !prev_valid) begin
                check("sb_nonempty", 768'(sb_q.size() != 0), 768'(1));
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    check("round_keys", kif.round_keys_out, e.keys);
                    check("latency", 768'(cyc), 768'(e.due));
                    check("done_with_valid", 768'(kif.keys_done_out), 768'(1));
                end
            end else begin
                check("done_quiet", 768'(kif.keys_done_out), 768'(0));
            end
            prev_valid = kif.keys_valid_out;
        end
    end

    // Caller is at a negedge; returns at the negedge right after the accepting edge.
    task automatic do_load(input logic [63:0] k, input logic dec);
        int unsigned n;
        n = 0;
        while (!kif.key_ready_out && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait", 768'(kif.key_ready_out), 768'(1));
        kif.key_in       = k;
        kif.decrypt_in   = dec;
        kif.key_valid_in = 1'b1;
        @(negedge clk);
        kif.key_valid_in = 1'b0;
        kif.key_in       = {$urandom, $urandom};
        kif.decrypt_in   = 1'($urandom_range(0, 1));
        sb_q.push_back('{ref_sched(k, dec), cyc + 16});
        loads++;
    endtask

    task automatic wait_valid();
        int unsigned n;
        n = 0;
        while (!kif.keys_valid_out && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("valid_timeout", 768'(kif.keys_valid_out), 768'(1));
    endtask

    initial begin
        logic busy_ready;
        rst              = 1'b1;
        kif.key_in       = '0;
        kif.key_valid_in = 1'b0;
        kif.decrypt_in   = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", 768'(kif.key_ready_out), 768'(1));
        check("rst_valid", 768'(kif.keys_valid_out), 768'(0));
        check("rst_done", 768'(kif.keys_done_out), 768'(0));
        check("rst_keys", kif.round_keys_out, '0);
        rst = 1'b0;
        @(negedge clk);

        do_load(VEC_KEY, 1'b0);
        wait_valid();
        check("enc_slot0", 768'(slot_of(kif.round_keys_out, 0)), 768'(VEC_K1));
        check("enc_slot15", 768'(slot_of(kif.round_keys_out, 15)), 768'(VEC_K16));

        @(negedge clk);
        do_load(VEC_KEY, 1'b1);
        wait_valid();
        check("dec_slot0", 768'(slot_of(kif.round_keys_out, 0)), 768'(VEC_K16));
        check("dec_slot15", 768'(slot_of(kif.round_keys_out, 15)), 768'(VEC_K1));

        do_load(VEC_KEY, 1'b0);
        busy_ready = 1'b0;
        for (int k = 0; k < 16; k++) begin
            busy_ready |= kif.key_ready_out;
            if (k == 4) begin
                kif.key_in       = 64'h0;
                kif.decrypt_in   = 1'b1;
                kif.key_valid_in = 1'b1;
            end
            if (k == 5) kif.key_valid_in = 1'b0;
            @(negedge clk);
        end
        check("busy_ready_low", 768'(busy_ready), 768'(0));
        check("busy_valid", 768'(kif.keys_valid_out), 768'(1));
        check("busy_slot0", 768'(slot_of(kif.round_keys_out, 0)), 768'(VEC_K1));
        check("busy_slot15", 768'(slot_of(kif.round_keys_out, 15)), 768'(VEC_K16));

        do_load({$urandom, $urandom}, 1'b1);
        check("b2b_valid_drop", 768'(kif.keys_valid_out), 768'(0));
        wait_valid();
        do_load({$urandom, $urandom}, 1'b0);
        wait_valid();

        do_load({$urandom, $urandom}, 1'b0);
        repeat (7) @(negedge clk);
        void'(sb_q.pop_back());
        aborted++;
        rst = 1'b1;
        kif.key_valid_in = 1'b1;
        @(negedge clk);
        check("abort_keys", kif.round_keys_out, '0);
        check("abort_valid", 768'(kif.keys_valid_out), 768'(0));
        check("abort_ready", 768'(kif.key_ready_out), 768'(1));
        check("abort_done", 768'(kif.keys_done_out), 768'(0));
        kif.key_valid_in = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        do_load({$urandom, $urandom}, 1'($urandom_range(0, 1)));
        wait_valid();

        for (int i = 0; i < 1000; i++) begin
            repeat ($urandom_range(0, 5)) @(negedge clk);
            do_load({$urandom, $urandom}, 1'($urandom_range(0, 1)));
            wait_valid();
        end

        repeat (3) @(negedge clk);
        check("sb_drained", 768'(sb_q.size()), 768'(0));
        check("done_count", 768'(done_pulses), 768'(loads - aborted));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
